// File: rtl/branch_pkg.sv
// Shared constants and helpers for the sequential branch resolver.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic int ndig(input int xlen, input int nib);
        return xlen / nib;
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

    function automatic logic is_signed(input logic [2:0] f3);
        return f3[2:1] != 2'b11;
    endfunction

    function automatic logic br_taken(
        input logic [2:0] f3,
        input logic       eq,
        input logic       lt
    );
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:  t = eq;
            F3_BNE:  t = !eq;
            F3_BLT:  t = lt;
            F3_BLTU: t = lt;
            F3_BGE:  t = !lt;
            F3_BGEU: t = !lt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Request/response bundle between the branch issuer and branch_seq.
interface branch_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] pc_next;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, funct3, pc, imm, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, taken, pc_next, illegal, busy
    );

    modport slave (
        input  in_valid, funct3, pc, imm, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, taken, pc_next, illegal, busy
    );
endinterface

// File: rtl/branch_seq_digit_cmp.sv
// Combinational NIB-bit digit comparator shared by all digit positions.
module digit_cmp #(
    parameter int NIB = 4
) (
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    output logic           eq,
    output logic           lt
);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

// File: rtl/branch_seq.sv
// Multi-cycle B-type resolver, one digit per cycle, MSB digit first.
// BRANCH_SEQ_EARLY_EXIT_EN: stop at the first differing digit.
import branch_pkg::*;

module branch_seq #(
    parameter int XLEN = 32,
    parameter int NIB  = 4
) (
    input logic         clk,
    input logic         rst_n,
    branch_seq_if.slave bus
);
    localparam int NDIG = ndig(XLEN, NIB);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

    logic [1:0]      state;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] a_q, b_q, pc_q, imm_q, pc_next_q;
    logic [2:0]      f3_q;
    logic            taken_q, illegal_q;
    logic [NIB-1:0]  a_dig, b_dig;
    logic            d_eq, d_lt, fin, r_eq, r_lt, r_taken;
    logic            accept, sgn;

    assign accept = bus.in_valid && bus.in_ready;
    assign sgn    = is_signed(bus.funct3);
    assign a_dig  = a_q[idx*NIB +: NIB];
    assign b_dig  = b_q[idx*NIB +: NIB];

    digit_cmp #(.NIB(NIB)) u_cmp (
        .a  (a_dig),
        .b  (b_dig),
        .eq (d_eq),
        .lt (d_lt)
    );

`ifdef BRANCH_SEQ_EARLY_EXIT_EN
    assign fin  = !d_eq || (idx == '0);
    assign r_eq = d_eq;
    assign r_lt = d_lt;
`else
    // Constant time: remember the first mismatch, keep scanning to digit 0.
    logic found_q, lt_hold;

    assign fin  = (idx == '0);
    assign r_eq = !found_q && d_eq;
    assign r_lt = found_q ? lt_hold : d_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_q <= 1'b0;
            lt_hold <= 1'b0;
        end else if (state == S_CMP) begin
            if (fin) begin
                found_q <= 1'b0;
            end else if (!found_q && !d_eq) begin
                found_q <= 1'b1;
                lt_hold <= d_lt;
            end
        end
    end
`endif

    assign r_taken = br_taken(f3_q, r_eq, r_lt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= IDX_MAX;
            a_q       <= '0;
            b_q       <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            f3_q      <= '0;
            taken_q   <= 1'b0;
            pc_next_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            unique case (1'b1)
                state == S_IDLE: begin
                    if (accept) begin
                        a_q   <= {bus.rs1_data[XLEN-1] ^ sgn,
                                  bus.rs1_data[XLEN-2:0]};
                        b_q   <= {bus.rs2_data[XLEN-1] ^ sgn,
                                  bus.rs2_data[XLEN-2:0]};
                        pc_q  <= bus.pc;
                        imm_q <= bus.imm;
                        f3_q  <= bus.funct3;
                        taken_q   <= 1'b0;
                        illegal_q <= is_illegal(bus.funct3);
                        pc_next_q <= bus.pc + XLEN'(4);
                        state <= is_illegal(bus.funct3) ? S_DONE : S_CMP;
                    end
                end
                state == S_CMP: begin
                    if (fin) begin
                        taken_q   <= r_taken;
                        pc_next_q <= r_taken ? pc_q + imm_q
                                             : pc_q + XLEN'(4);
                        state     <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                state == S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                        idx   <= IDX_MAX;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.taken     = taken_q;
    assign bus.pc_next   = pc_next_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_branch_seq.sv
// Randomized and directed bench for branch_seq against a behavioural model.
module tb_branch_seq;
    import branch_pkg::*;

    localparam int XLEN = 32;
    localparam int NIB  = 4;
    localparam int NDIG = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    branch_seq_if #(.XLEN(XLEN)) bus ();

    branch_seq #(.XLEN(XLEN), .NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        logic slt, ult;
        slt = $signed(a) < $signed(b);
        ult = a < b;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return slt;
            3'd5:    return !slt;
            3'd6:    return ult;
            3'd7:    return !ult;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles spent comparing; 0 for an illegal funct3.
    function automatic int ref_k(input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
        logic [31:0] x;
        if (f3 == 3'd2 || f3 == 3'd3) return 0;
        x = a ^ b;
`ifdef BRANCH_SEQ_EARLY_EXIT_EN
        for (int d = NDIG - 1; d >= 0; d--)
            if (x[d*NIB +: NIB] != 0) return NDIG - d;
`endif
        return NDIG;
    endfunction

    task automatic run(input logic [2:0] f3, input logic [31:0] p,
                       input logic [31:0] im, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
        logic        t_exp, il_exp;
        logic [31:0] pn_exp;
        int          lat, k;
        t_exp  = ref_taken(f3, a, b);
        il_exp = (f3 == 3'd2 || f3 == 3'd3);
        pn_exp = t_exp ? p + im : p + 32'd4;
        k      = ref_k(f3, a, b);
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.pc       = p;
        bus.imm      = im;
        bus.rs1_data = a;
        bus.rs2_data = b;
        check("in_ready_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.pc       = $urandom;
        bus.imm      = $urandom;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, k + 1);
        check("taken", bus.taken, t_exp);
        check("pc_next", bus.pc_next, pn_exp);
        check("illegal", bus.illegal, il_exp);
        check("in_ready_done", bus.in_ready, 0);
        check("busy_done", bus.busy, 1);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_taken", bus.taken, t_exp);
            check("hold_pc", bus.pc_next, pn_exp);
            check("hold_illegal", bus.illegal, il_exp);
            check("hold_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_valid", bus.out_valid, 0);
        check("release_ready", bus.in_ready, 1);
        check("release_busy", bus.busy, 0);
    endtask

    task automatic reset_mid;
        bit seen;
        bus.in_valid = 1'b1;
        bus.funct3   = F3_BEQ;
        bus.pc       = 32'h600;
        bus.imm      = 32'h40;
        bus.rs1_data = 32'hCAFE0000;
        bus.rs2_data = 32'hCAFE0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_taken", bus.taken, 0);
        check("rst_pc_next", bus.pc_next, 0);
        check("rst_illegal", bus.illegal, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst_no_output", seen, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.funct3    = '0;
        bus.pc        = '0;
        bus.imm       = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        #2;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_taken", bus.taken, 0);
        check("reset_pc_next", bus.pc_next, 0);
        check("reset_illegal", bus.illegal, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(F3_BEQ, 32'h100, 32'h20, 32'h12345678, 32'h12345678, 0);
        run(F3_BLT, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1, 0);
        run(F3_BLTU, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1, 0);
        run(F3_BGE, 32'h300, 32'h10, 32'h80000000, 32'h7FFFFFFF, 0);
        run(F3_BNE, 32'h400, 32'h8, 32'h10, 32'h11, 0);
        run(3'b010, 32'h500, 32'h80, 32'h1, 32'h1, 0);
        run(3'b011, 32'h504, 32'h80, 32'h2, 32'h1, 0);
        run(F3_BEQ, 32'hFFFFFFFC, 32'h8, 32'h5, 32'h5, 0);
        run(F3_BGEU, 32'h700, 32'hFFFFFFF0, 32'h9, 32'h9, 5);
        run(F3_BLT, 32'h800, 32'h10, 32'h7, 32'h8, 0);
        reset_mid();
        run(F3_BNE, 32'h900, 32'h24, 32'hCAFE0001, 32'hCAFE0000, 0);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = a;
                2:       b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = a ^ 32'($urandom_range(0, 15));
            endcase
            run(3'($urandom_range(0, 7)), $urandom & 32'hFFFFFFFC,
                $urandom, a, b, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
